axi_burst_checker: RTL and testbench

- Synthesizable AXI4 master that sits directly upstream of `axi_sim_mem` (or any AXI4 slave memory) and drives its slave port.
- On a start pulse it writes one INCR burst of a deterministic data pattern, waits for the B response, then reads the same burst back and compares every beat.
- Used as a self-checking traffic source in simulation and FPGA bring-up. Reports done, error flags and a mismatch count.

---
 rtl/axi_burst_checker.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_axi_burst_checker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_checker.sv
// AXI4 burst write/read-back checker.
// Writes one INCR burst of a seed-derived pattern, waits for B, reads the burst back and compares
// every beat. Reports a one-cycle done_o plus sticky error flags and a saturating mismatch count.
//   clk_i, rst_ni                    : clock, asynchronous active-low reset
//   start_i, addr_i, len_i, seed_i   : test request (sampled on an accepted start)
//   busy_o, done_o, error_o          : status
//   resp_err_o, last_err_o, bound_err_o, mismatch_cnt_o : sticky results until the next start
//   axi_req_o / axi_rsp_i            : AXI4 master port

package axi_burst_checker_pkg;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 128;
  localparam int unsigned IdWidth   = 6;
  localparam int unsigned UserWidth = 2;

  typedef struct packed {
    logic [IdWidth-1:0]     id;
    logic [AddrWidth-1:0]   addr;
    logic [7:0]             len;
    logic [2:0]             size;
    logic [1:0]             burst;
    logic                   lock;
    logic [3:0]             cache;
    logic [2:0]             prot;
    logic [3:0]             qos;
    logic [3:0]             region;
    logic [5:0]             atop;
    logic [UserWidth-1:0]   user;
  } aw_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
    logic [UserWidth-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]     id;
    logic [1:0]             resp;
    logic [UserWidth-1:0]   user;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]     id;
    logic [AddrWidth-1:0]   addr;
    logic [7:0]             len;
    logic [2:0]             size;
    logic [1:0]             burst;
    logic                   lock;
    logic [3:0]             cache;
    logic [2:0]             prot;
    logic [3:0]             qos;
    logic [3:0]             region;
    logic [UserWidth-1:0]   user;
  } ar_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]     id;
    logic [DataWidth-1:0]   data;
    logic [1:0]             resp;
    logic                   last;
    logic [UserWidth-1:0]   user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } axi_resp_t;
endpackage

module axi_burst_checker #(
  parameter int unsigned        AddrWidth  = 64,
  parameter int unsigned        DataWidth  = 128,
  parameter int unsigned        IdWidth    = 6,
  parameter int unsigned        UserWidth  = 2,
  parameter logic [IdWidth-1:0] AxiId      = '0,
  parameter type                axi_req_t  = axi_burst_checker_pkg::axi_req_t,
  parameter type                axi_resp_t = axi_burst_checker_pkg::axi_resp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [7:0]           len_i,
  input  logic [31:0]          seed_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic                 resp_err_o,
  output logic                 last_err_o,
  output logic                 bound_err_o,
  output logic [15:0]          mismatch_cnt_o,
  output axi_req_t             axi_req_o,
  input  axi_resp_t            axi_rsp_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned SizeBits  = $clog2(StrbWidth);
  localparam int unsigned Words     = DataWidth / 32;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAw   = 3'd1;
  localparam logic [2:0] StW    = 3'd2;
  localparam logic [2:0] StB    = 3'd3;
  localparam logic [2:0] StAr   = 3'd4;
  localparam logic [2:0] StR    = 3'd5;
  localparam logic [2:0] StDone = 3'd6;

  logic [2:0]           state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [7:0]           len_q, len_d;
  logic [31:0]          seed_q, seed_d;
  logic [7:0]           beat_q, beat_d;
  logic                 resp_err_q, resp_err_d;
  logic                 last_err_q, last_err_d;
  logic                 bound_err_q, bound_err_d;
  logic [15:0]          mismatch_q, mismatch_d;

  logic [31:0] span;
  logic        cross_4k;
  logic        last_beat;

  // Word k of beat i is seed + i*Words + k; word 0 sits in the LSBs.
  function automatic logic [DataWidth-1:0] beat_data(logic [31:0] seed, logic [7:0] idx);
    logic [DataWidth-1:0] d;
    d = '0;
    for (int unsigned k = 0; k < Words; k++) begin
      d[32*k +: 32] = seed + 32'(idx) * 32'(Words) + 32'(k);
    end
    return d;
  endfunction

  // Byte offset inside the 4 KiB page plus burst length in bytes.
  assign span = 32'(addr_i[11:0] & ~12'(StrbWidth - 1)) +
                (32'(len_i) + 32'd1) * 32'(StrbWidth);
  assign cross_4k  = span > 32'd4096;
  assign last_beat = beat_q == len_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    seed_d      = seed_q;
    beat_d      = beat_q;
    resp_err_d  = resp_err_q;
    last_err_d  = last_err_q;
    bound_err_d = bound_err_q;
    mismatch_d  = mismatch_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d      = addr_i & ~(AddrWidth'(StrbWidth) - AddrWidth'(1));
          len_d       = len_i;
          seed_d      = seed_i;
          beat_d      = '0;
          resp_err_d  = 1'b0;
          last_err_d  = 1'b0;
          bound_err_d = cross_4k;
          mismatch_d  = '0;
          state_d     = cross_4k ? StDone : StAw;
        end
      end
      StAw: if (axi_rsp_i.aw_ready) state_d = StW;
      StW: begin
        if (axi_rsp_i.w_ready) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = StB;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      StB: begin
        if (axi_rsp_i.b_valid) begin
          if (axi_rsp_i.b.resp != 2'b00) resp_err_d = 1'b1;
          state_d = StAr;
        end
      end
      StAr: if (axi_rsp_i.ar_ready) state_d = StR;
      StR: begin
        if (axi_rsp_i.r_valid) begin
          if (axi_rsp_i.r.data != beat_data(seed_q, beat_q) && mismatch_q != 16'hFFFF) begin
            mismatch_d = mismatch_q + 16'd1;
          end
          if (axi_rsp_i.r.resp != 2'b00) resp_err_d = 1'b1;
          if (axi_rsp_i.r.last != last_beat) last_err_d = 1'b1;
          // An early r_last ends the read; so does the final expected beat.
          if (axi_rsp_i.r.last || last_beat) begin
            state_d = StDone;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      len_q       <= '0;
      seed_q      <= '0;
      beat_q      <= '0;
      resp_err_q  <= 1'b0;
      last_err_q  <= 1'b0;
      bound_err_q <= 1'b0;
      mismatch_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      seed_q      <= seed_d;
      beat_q      <= beat_d;
      resp_err_q  <= resp_err_d;
      last_err_q  <= last_err_d;
      bound_err_q <= bound_err_d;
      mismatch_q  <= mismatch_d;
    end
  end

  always_comb begin
    axi_req_o = '0;

    axi_req_o.aw.id     = AxiId;
    axi_req_o.aw.addr   = addr_q;
    axi_req_o.aw.len    = len_q;
    axi_req_o.aw.size   = 3'(SizeBits);
    axi_req_o.aw.burst  = 2'b01;
    axi_req_o.aw.user   = {UserWidth{1'b0}};
    axi_req_o.aw_valid  = state_q == StAw;

    axi_req_o.w.data    = beat_data(seed_q, beat_q);
    axi_req_o.w.strb    = '1;
    axi_req_o.w.last    = last_beat;
    axi_req_o.w.user    = {UserWidth{1'b0}};
    axi_req_o.w_valid   = state_q == StW;

    axi_req_o.b_ready   = state_q == StB;

    axi_req_o.ar.id     = AxiId;
    axi_req_o.ar.addr   = addr_q;
    axi_req_o.ar.len    = len_q;
    axi_req_o.ar.size   = 3'(SizeBits);
    axi_req_o.ar.burst  = 2'b01;
    axi_req_o.ar.user   = {UserWidth{1'b0}};
    axi_req_o.ar_valid  = state_q == StAr;

    axi_req_o.r_ready   = state_q == StR;
  end

  assign busy_o         = state_q != StIdle && state_q != StDone;
  assign done_o         = state_q == StDone;
  assign resp_err_o     = resp_err_q;
  assign last_err_o     = last_err_q;
  assign bound_err_o    = bound_err_q;
  assign mismatch_cnt_o = mismatch_q;
  assign error_o        = resp_err_q | last_err_q | bound_err_q | (mismatch_q != 16'd0);

  logic unused_rsp;
  assign unused_rsp = ^{axi_rsp_i.b.id, axi_rsp_i.b.user, axi_rsp_i.r.id, axi_rsp_i.r.user};

endmodule

// File: tb/tb_axi_burst_checker.sv
// Self-checking bench for axi_burst_checker with a behavioural AXI slave memory.
module tb_axi_burst_checker;
  import axi_burst_checker_pkg::*;

  localparam int unsigned BeatBytes = 16;
  localparam int unsigned Words     = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] addr = '0;
  logic [7:0]  len = '0;
  logic [31:0] seed = '0;
  logic        busy, done, error, resp_err, last_err, bound_err;
  logic [15:0] mis_cnt;
  axi_req_t    req;
  axi_resp_t   rsp = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_burst_checker dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .addr_i         (addr),
    .len_i          (len),
    .seed_i         (seed),
    .busy_o         (busy),
    .done_o         (done),
    .error_o        (error),
    .resp_err_o     (resp_err),
    .last_err_o     (last_err),
    .bound_err_o    (bound_err),
    .mismatch_cnt_o (mis_cnt),
    .axi_req_o      (req),
    .axi_rsp_i      (rsp)
  );

  // Slave configuration knobs.
  bit         bp = 1'b0;
  logic [1:0] b_resp_cfg = 2'b00;
  int         corrupt_beat = -1;
  int         early_last = -1;

  // Slave bookkeeping.
  logic [127:0] mem [longint unsigned];
  int           aw_cnt = 0, w_cnt = 0, viol = 0;
  logic [63:0]  wr_addr = '0, rd_addr = '0;
  logic [7:0]   wr_len = '0, rd_len = '0;
  int           wr_beat = 0, rd_beat = 0;
  bit           b_pend = 1'b0, rd_act = 1'b0;

  bit        hs_aw, hs_w, hs_b, hs_ar, hs_r;
  axi_req_t  cap_req;
  axi_resp_t cap_rsp;

  always @(posedge clk) begin
    hs_aw   <= req.aw_valid && rsp.aw_ready;
    hs_w    <= req.w_valid && rsp.w_ready;
    hs_b    <= rsp.b_valid && req.b_ready;
    hs_ar   <= req.ar_valid && rsp.ar_ready;
    hs_r    <= rsp.r_valid && req.r_ready;
    cap_req <= req;
    cap_rsp <= rsp;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      b_pend = 1'b0;
      rd_act = 1'b0;
      rsp    = '0;
    end else begin
      // A valid left waiting must still be there, unchanged.
      if (cap_req.aw_valid && !cap_rsp.aw_ready && (!req.aw_valid || req.aw !== cap_req.aw)) viol++;
      if (cap_req.w_valid && !cap_rsp.w_ready && (!req.w_valid || req.w !== cap_req.w)) viol++;
      if (cap_req.ar_valid && !cap_rsp.ar_ready && (!req.ar_valid || req.ar !== cap_req.ar)) viol++;
      if (req.aw_valid && req.w_valid) viol++;

      if (hs_aw) begin
        wr_addr = cap_req.aw.addr;
        wr_len  = cap_req.aw.len;
        wr_beat = 0;
        aw_cnt++;
        if (cap_req.aw.burst !== 2'b01 || cap_req.aw.size !== 3'd4) viol++;
      end
      if (hs_w) begin
        mem[longint'(wr_addr >> 4) + longint'(wr_beat)] = cap_req.w.data;
        if (cap_req.w.strb !== 16'hFFFF) viol++;
        if (cap_req.w.last !== (wr_beat == int'(wr_len))) viol++;
        w_cnt++;
        wr_beat++;
        if (cap_req.w.last) b_pend = 1'b1;
      end
      if (hs_b) b_pend = 1'b0;
      if (hs_ar) begin
        rd_addr = cap_req.ar.addr;
        rd_len  = cap_req.ar.len;
        rd_beat = 0;
        rd_act  = 1'b1;
      end
      if (hs_r) begin
        if (cap_rsp.r.last) rd_act = 1'b0;
        rd_beat++;
      end

      rsp          = '0;
      rsp.aw_ready = bp ? 1'($urandom % 2) : 1'b1;
      rsp.w_ready  = bp ? 1'($urandom % 2) : 1'b1;
      rsp.ar_ready = bp ? 1'($urandom % 2) : 1'b1;
      rsp.b_valid  = b_pend;
      rsp.b.resp   = b_resp_cfg;
      rsp.r_valid  = rd_act;
      if (rd_act) begin
        rsp.r.data = mem[longint'(rd_addr >> 4) + longint'(rd_beat)];
        if (rd_beat == corrupt_beat) rsp.r.data[0] = ~rsp.r.data[0];
        rsp.r.last = (rd_beat == int'(rd_len)) || (rd_beat == early_last);
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // The pattern is one continuous stream of 32-bit words counting up from the seed.
  function automatic logic [127:0] model_beat(input logic [31:0] s, input int b);
    logic [127:0] d;
    for (int k = 0; k < Words; k++) d[32*k +: 32] = s + 32'(b * Words + k);
    return d;
  endfunction

  task automatic run(input logic [63:0] a, input logic [7:0] l, input logic [31:0] s,
                     input string tag, output int cyc);
    logic [63:0] base;
    bit          bnd, e_mis, e_resp, e_last, e_err;
    int          beats_r, aw0, w0, v0;
    base    = a & ~64'hF;
    bnd     = (base % 4096) + (64'(l) + 1) * BeatBytes > 4096;
    beats_r = (early_last >= 0 && early_last < int'(l)) ? early_last + 1 : int'(l) + 1;
    e_mis   = !bnd && corrupt_beat >= 0 && corrupt_beat < beats_r;
    e_resp  = !bnd && b_resp_cfg != 2'b00;
    e_last  = !bnd && early_last >= 0 && early_last < int'(l);
    e_err   = bnd | e_mis | e_resp | e_last;
    aw0 = aw_cnt; w0 = w_cnt; v0 = viol;

    @(negedge clk);
    addr = a; len = l; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy"}, 128'(busy), 128'(!bnd));
    if (!bnd) begin
      // Start while busy must be ignored.
      seed  = ~s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " done"}, 128'(done), 128'(1));
    check({tag, " error"}, 128'(error), 128'(e_err));
    check({tag, " resp_err"}, 128'(resp_err), 128'(e_resp));
    check({tag, " last_err"}, 128'(last_err), 128'(e_last));
    check({tag, " bound_err"}, 128'(bound_err), 128'(bnd));
    check({tag, " mismatch"}, 128'(mis_cnt), 128'(e_mis));
    check({tag, " busy@done"}, 128'(busy), 128'(0));
    // Start coincident with done is ignored; flags hold afterwards.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check({tag, " idle busy"}, 128'(busy), 128'(0));
    check({tag, " held error"}, 128'(error), 128'(e_err));
    check({tag, " aw count"}, 128'(aw_cnt - aw0), 128'(bnd ? 0 : 1));
    check({tag, " w count"}, 128'(w_cnt - w0), 128'(bnd ? 0 : int'(l) + 1));
    check({tag, " protocol"}, 128'(viol - v0), 128'(0));
    if (!bnd) begin
      for (int b = 0; b <= int'(l); b++) begin
        check({tag, " mem"}, mem[longint'(base >> 4) + longint'(b)], model_beat(s, b));
      end
    end
  endtask

  initial begin
    int cyc;
    int guard;
    int w0;
    #3;
    check("rst busy", 128'(busy), 128'(0));
    check("rst done", 128'(done), 128'(0));
    check("rst error", 128'(error), 128'(0));
    check("rst count", 128'(mis_cnt), 128'(0));
    check("rst valids", 128'({req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready}),
          128'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run(64'h1000, 8'd3, 32'h0, "basic", cyc);
    check("basic beat0", mem[64'h100], 128'h00000003_00000002_00000001_00000000);

    run(64'h0, 8'd255, 32'h1234_5678, "full page", cyc);

    run(64'h10, 8'd255, 32'h0, "cross 4k", cyc);
    check("cross 4k latency", 128'(cyc + 1 <= 3), 128'(1));

    corrupt_beat = 2;
    b_resp_cfg   = 2'b10;
    run(64'h3000, 8'd7, $urandom, "corrupt", cyc);
    corrupt_beat = -1;
    b_resp_cfg   = 2'b00;

    bp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run({32'h0, $urandom}, 8'($urandom_range(0, 15)), $urandom, "backpressure", cyc);
    end
    bp = 1'b0;

    early_last = 1;
    run(64'h4000, 8'd3, $urandom, "early last", cyc);
    early_last = -1;

    // Reset while beat 2 of the write is presented.
    w0 = w_cnt;
    @(negedge clk);
    addr = 64'h6000; len = 8'd7; seed = 32'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (w_cnt - w0 < 2 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("mid-W reached", 128'(w_cnt - w0 == 2 && req.w_valid), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async rst valids",
          128'({req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready}), 128'(0));
    check("async rst busy", 128'(busy), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(64'h5000, 8'd3, 32'hDEADBEEF, "after reset", cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
